// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end.
//  - RESET_PC_DEFAULT : address fetched first after reset
//  - OP_* / FN_MSB    : positions of the opcode and funct fields in an instruction word
//  - fetch_entry_t    : one buffered fetch result {instr, pc}
//  - fetch_state_t    : fetch sequencer states
//  - word_align()     : clears the byte-offset bits of an address
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int FN_MSB = 5;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {instr, pc} entries for the ID stage.
// Show-ahead read: dout always presents the head entry, pop only advances it.
// Ports:
//  clk, reset (async, active-low)
//  flush        : empties the FIFO; wins over a same-cycle push and pop
//  push, din    : write one entry (ignored when full)
//  pop          : drop the head entry (ignored when empty)
//  dout         : head entry (undefined contents while count == 0)
//  count        : number of entries held, 0..DEPTH
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  output fetch_entry_t dout,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (cnt != CW'(DEPTH)) && !flush;
  assign do_pop  = pop && (cnt != '0) && !flush;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by cnt alone,
  // which keeps the array mappable to plain registers or RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage of the 5-stage MIPS pipeline.
// Generates the fetch PC, issues in-order reads to instruction memory under a
// credit limit of DEPTH words (outstanding + buffered), buffers returned words
// and presents {instr, pc, pc+4} plus decoded opcode/funct to the ID stage.
// Redirects from later stages restart fetch at a new PC; words still in flight
// at that point are counted into a discard counter and dropped on return.
// Ports:
//  clk, reset (async, active-low)
//  imem_req_valid/ready/addr : instruction memory read request
//  imem_rsp_valid/data       : in-order read data
//  redirect_valid/pc         : branch/jump redirect, bits[1:0] of pc ignored
//  id_valid/ready            : handshake to ID (ready low = stall)
//  id_instr/pc/pc_plus4      : delivered instruction, its address, link value
//  id_opcode/funct           : instruction fields for Control
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [5:0]  id_opcode,
  output logic [5:0]  id_funct
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_state_t  state, state_next;
  logic          issue_en;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] inflight, inflight_next;
  logic [CW-1:0] discard;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credits_used;
  logic          accept;
  logic          rsp_fire;
  logic          drop;
  logic          fifo_push;
  logic          fifo_pop;
  fetch_entry_t  fifo_din;
  fetch_entry_t  fifo_head;

  // PC tag queue: one address per accepted request, consumed in order by responses.
  logic [31:0]   tag_q [DEPTH];
  logic [AW-1:0] tag_wr;
  logic [AW-1:0] tag_rd;

  // ---------------- sequencer ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_BOOT;
    else        state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    issue_en   = 1'b0;
    case (state)
      S_BOOT:  state_next = S_RUN;
      S_RUN:   issue_en   = 1'b1;
      default: state_next = S_BOOT;
    endcase
  end

  // ---------------- request issue ----------------
  // Words being discarded still count as inflight, so they hold credit until
  // they return; this is what bounds the FIFO at DEPTH entries.
  assign credits_used   = {1'b0, inflight} + {1'b0, fifo_count};
  assign imem_req_valid = issue_en && (credits_used < (CW + 1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_fire      = imem_rsp_valid && (inflight != '0);
  assign drop          = rsp_fire && (discard != '0);
  assign inflight_next = inflight + CW'(accept) - CW'(rsp_fire);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
    end else begin
      inflight <= inflight_next;
      if (redirect_valid) begin
        fetch_pc <= word_align(redirect_pc);
        // Everything still outstanding after this edge belongs to the old path,
        // including a request accepted in this very cycle.
        discard  <= inflight_next;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (drop)   discard  <= discard - 1'b1;
      end
    end
  end

  // ---------------- PC tag queue ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_wr <= '0;
      tag_rd <= '0;
    end else begin
      if (accept)   tag_wr <= tag_wr + 1'b1;
      if (rsp_fire) tag_rd <= tag_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) tag_q[tag_wr] <= fetch_pc;
  end

  // ---------------- instruction buffer ----------------
  assign fifo_push = rsp_fire && !drop;
  assign fifo_pop  = id_valid && id_ready;
  assign fifo_din  = '{instr: imem_rsp_data, pc: tag_q[tag_rd]};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .count (fifo_count)
  );

  // ---------------- ID interface ----------------
  // Data is forced to zero while nothing is valid so ID never sees stale words.
  assign id_valid    = (fifo_count != '0);
  assign id_instr    = id_valid ? fifo_head.instr : 32'd0;
  assign id_pc       = id_valid ? fifo_head.pc : 32'd0;
  assign id_pc_plus4 = id_valid ? fifo_head.pc + 32'd4 : 32'd0;
  assign id_opcode   = id_instr[OP_MSB:OP_LSB];
  assign id_funct    = id_instr[FN_MSB:0];

  rsp_without_request : assert property (
    @(posedge clk) disable iff (!reset) imem_rsp_valid |-> (inflight != '0)
  );

endmodule
